// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: hazard/redirect controls and instruction memory in, IF/ID register and status out.
// The fetch unit connects through the slave modport; the driving side uses master.
interface fetch_unit_if;
    logic        stall;
    logic        flush;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic [31:0] i_in;
    logic [31:0] address;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fetch_err;
    logic [31:0] fetch_count;

    modport master (
        output stall, flush, pc_src, branch_target, jump_index, jr_target, i_in,
        input  address, if_id_instr, if_id_pc4, if_id_valid, fetch_err, fetch_count
    );

    modport slave (
        input  stall, flush, pc_src, branch_target, jump_index, jr_target, i_in,
        output address, if_id_instr, if_id_pc4, if_id_valid, fetch_err, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register with redirect/stall control and the IF/ID pipeline register.
// A redirect moves the PC even under stall; the slot at the current PC is still captured unless flushed.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input logic        clk,
    input logic        rst,
    fetch_unit_if.slave bus
);
    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;
    localparam logic [1:0] SRC_JR     = 2'b11;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic        target_misaligned;

    assign pc_plus4 = pc_q + 32'd4;

    // Jump keeps the region bits of the instruction in ID, i.e. the delay slot's neighbour.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        redirect_target   = pc_q;
        target_misaligned = 1'b0;
        unique case (bus.pc_src)
            SRC_BRANCH: begin
                redirect_target   = bus.branch_target;
                target_misaligned = |bus.branch_target[1:0];
            end
            SRC_JUMP:   redirect_target = {pc4_q[31:28], bus.jump_index, 2'b00};
            SRC_JR: begin
                redirect_target   = bus.jr_target;
                target_misaligned = |bus.jr_target[1:0];
            end
            default:    redirect_target = pc_q;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        err_d = err_q | target_misaligned;
        if (bus.pc_src != SRC_SEQ) begin
            pc_d = {redirect_target[31:2], 2'b00};
        end else if (!bus.stall) begin
            pc_d = pc_plus4;
        end
    end

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;
        if (bus.flush) begin
            instr_d = NOP_WORD;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            instr_d = bus.i_in;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= 32'h0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign bus.address     = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc4   = pc4_q;
    assign bus.if_id_valid = valid_q;
    assign bus.fetch_err   = err_q;
    assign bus.fetch_count = count_q;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
REQ-002 Parameter: NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  hold PC and IF/ID (load-use hazard from ID).
REQ-006 flush  input  1  replace the next IF/ID contents with a bubble.
REQ-007 pc_src  input  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 jump-register.
REQ-008 branch_target  input  32  byte address for pc_src=01.
REQ-009 jump_index  input  26  instr_index field for pc_src=10.
REQ-010 jr_target  input  32  register value for pc_src=11.
REQ-011 i_in  input  32  instruction word returned by instruction memory for the current address.
REQ-012 address  output  32  byte address driven to instruction memory; equals the PC register, combinational.
REQ-013 if_id_instr  output  32  registered instruction for ID.
REQ-014 if_id_pc4  output  32  registered PC+4 of that instruction.
REQ-015 if_id_valid  output  1  1 = if_id_instr is a real fetched instruction, 0 = bubble.
REQ-016 fetch_err  output  1  sticky flag, set on any misaligned redirect target.
REQ-017 fetch_count  output  32  count of instructions accepted into IF/ID since reset.

Function
REQ-018 The PC register SHALL update only on rising clk, with priority: rst > redirect (pc_src!=00) > stall > sequential.
REQ-019 Sequential: PC <= PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000, no flag).
REQ-020 Branch: PC <= {branch_target[31:2],2'b00}.
REQ-021 Jump: PC <= {if_id_pc4[31:28], jump_index, 2'b00}.
REQ-022 Jump-register: PC <= {jr_target[31:2],2'b00}.
REQ-023 A redirect SHALL take effect even when stall=1 (redirect overrides stall for the PC only).
REQ-024 If the selected branch/jr target has bits [1:0] != 00, fetch_err SHALL be set on that edge and stay 1 until rst; the PC still takes the word-aligned value.
REQ-025 IF/ID update priority: rst > flush > stall > capture.
REQ-026 flush=1: if_id_instr <= NOP_WORD, if_id_pc4 <= 0, if_id_valid <= 0, regardless of stall.
REQ-027 stall=1, flush=0: IF/ID holds all values; fetch_count holds.
REQ-028 Capture (flush=0, stall=0): if_id_instr <= i_in, if_id_pc4 <= PC+4, if_id_valid <= 1, fetch_count <= fetch_count+1 (wraps modulo 2^32).
REQ-029 Redirect without flush SHALL still capture the instruction at the current PC (branch delay slot executes).
REQ-030 Fetch latency: instruction at address A appears on if_id_instr one clk edge after address=A, with no stall.
REQ-031 No output other than address SHALL depend combinationally on any input.

Reset
REQ-032 While rst=1 (asserted asynchronously, at any point including mid-stall or mid-redirect): PC = RESET_PC, address = RESET_PC, if_id_instr = NOP_WORD, if_id_pc4 = 0, if_id_valid = 0, fetch_err = 0, fetch_count = 0.
REQ-033 On the first rising clk after rst deasserts, with stall=0 and flush=0, IF/ID SHALL capture the word at RESET_PC and PC SHALL become RESET_PC+4.

Verification
REQ-034 Sequential run: memory words W0..W3 at 0x0..0xC, no stall -> address 0,4,8,C on successive cycles; if_id_instr W0..W3 one cycle later, if_id_pc4 4,8,C,10; fetch_count reaches 4.
REQ-035 Stall: stall=1 for 2 cycles while address=0x8 -> address stays 0x8, IF/ID holds W1/pc4=0x8, fetch_count unchanged; resumes with W2.
REQ-036 Branch plus flush: pc_src=01, branch_target=0x40, flush=1 at address 0x10 -> next address 0x40, if_id_valid=0, if_id_instr=0; next cycle captures mem[0x40]. Same test with flush=0 -> delay slot word at 0x10 captured.
REQ-037 Jump and jr: if_id_pc4=0x1000_0008, jump_index=26'h0000_010 -> address 0x1000_0040; jr_target=0x0000_0123 -> address 0x0000_0120, fetch_err=1 and stays 1.
REQ-038 Wrap: force PC to 0xFFFF_FFFC via jr -> following address 0x0000_0000, if_id_pc4=0x0000_0000, no error.
REQ-039 Async reset mid-stall: assert rst between clock edges with stall=1 -> all outputs reach reset values immediately, before the next edge.
